// File: rtl/yacht_pkg.sv
// ------------------------------------------------------------------
// yacht_pkg : shared types and constants for the Yacht dice datapath
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package yacht_pkg;

  localparam int          DIE_W         = 3;
  localparam int          DEF_NUM_DICE  = 5;
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ROLL_IDLE   = 2'd0,
    ROLL_TUMBLE = 2'd1,
    ROLL_DONE   = 2'd2
  } roll_state_t;

  // Galois form: shift right, fold the polynomial in when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic die_face_ok(input logic [DIE_W-1:0] v);
    return (v >= 3'd1) && (v <= 3'd6);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ------------------------------------------------------------------
// lfsr16 : free-running 16-bit Galois LFSR with reset seed
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lfsr16
  import yacht_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED;
    end else begin
      state <= lfsr_step(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dice_roll_ctrl.sv
// ------------------------------------------------------------------
// dice_roll_ctrl : roll sequencer, dice registers and hold mask
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dice_roll_ctrl
  import yacht_pkg::*;
#(
  parameter int          NUM_DICE     = DEF_NUM_DICE,
  parameter int          TUMBLE_TICKS = 8,
  parameter int          TICK_DIV     = 5000000,
  parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      roll_trigger,
  input  logic                      hold_toggle,
  input  logic [2:0]                hold_sel,
  input  logic                      clear_holds,
  output logic [DIE_W*NUM_DICE-1:0] dice_out,
  output logic [NUM_DICE-1:0]       hold_mask,
  output logic                      busy,
  output logic                      roll_done,
  output logic                      dice_valid
);

  localparam int DW     = DIE_W * NUM_DICE;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_W = (TUMBLE_TICKS > 1) ? $clog2(TUMBLE_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TUMBLE_TICKS - 1);
  localparam logic [DW-1:0]     DICE_RESET = {NUM_DICE{3'd1}};

  roll_state_t         state, state_nxt;
  logic [DIV_W-1:0]    div_cnt, div_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic [DW-1:0]       dice_nxt, rolled;
  logic [NUM_DICE-1:0] mask_nxt, toggle_vec, edited;
  logic                clr_pend, clr_nxt;
  logic                valid_nxt;
  logic [15:0]         lfsr;
  logic                unused_lfsr;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  // Only the low 3*NUM_DICE bits feed the dice; fold the rest away.
  assign unused_lfsr = ^lfsr;

  always_comb begin
    toggle_vec = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      if (hold_toggle && (hold_sel == 3'(i))) begin
        toggle_vec[i] = 1'b1;
      end
    end
    edited = clear_holds ? '0 : (hold_mask ^ toggle_vec);
  end

  // Out-of-range candidates (0 or 7) leave the die where it was.
  always_comb begin
    rolled = dice_out;
    for (int i = 0; i < NUM_DICE; i++) begin
      if (!hold_mask[i] && die_face_ok(lfsr[DIE_W*i +: DIE_W])) begin
        rolled[DIE_W*i +: DIE_W] = lfsr[DIE_W*i +: DIE_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    tick_nxt  = tick_cnt;
    dice_nxt  = dice_out;
    mask_nxt  = hold_mask;
    clr_nxt   = clr_pend;
    valid_nxt = dice_valid;

    case (state)
      ROLL_IDLE: begin
        mask_nxt = edited;
        if (roll_trigger) begin
          div_nxt   = '0;
          tick_nxt  = '0;
          state_nxt = (&edited) ? ROLL_DONE : ROLL_TUMBLE;
        end
      end

      ROLL_TUMBLE: begin
        if (clear_holds) begin
          clr_nxt = 1'b1;
        end
        if (div_cnt == DIV_LAST) begin
          div_nxt  = '0;
          tick_nxt = tick_cnt + TICK_W'(1);
          dice_nxt = rolled;
          if (tick_cnt == TICK_LAST) begin
            state_nxt = ROLL_DONE;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end

      ROLL_DONE: begin
        valid_nxt = 1'b1;
        mask_nxt  = clr_pend ? '0 : edited;
        clr_nxt   = 1'b0;
        state_nxt = ROLL_IDLE;
      end

      default: begin
        state_nxt = ROLL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ROLL_IDLE;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      dice_out   <= DICE_RESET;
      hold_mask  <= '0;
      clr_pend   <= 1'b0;
      dice_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      tick_cnt   <= tick_nxt;
      dice_out   <= dice_nxt;
      hold_mask  <= mask_nxt;
      clr_pend   <= clr_nxt;
      dice_valid <= valid_nxt;
    end
  end

  assign busy      = (state == ROLL_TUMBLE);
  assign roll_done = (state == ROLL_DONE);

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_ctrl.sv
// ------------------------------------------------------------------
// tb_dice_roll_ctrl : self-checking bench with a cycle-level roll model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dice_roll_ctrl;

  localparam int          ND   = 5;
  localparam int          TT   = 4;
  localparam int          TD   = 1;
  localparam int          NCYC = TT * TD;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          roll_trigger;
  logic          hold_toggle;
  logic [2:0]    hold_sel;
  logic          clear_holds;
  logic [3*ND-1:0] dice_out;
  logic [ND-1:0] hold_mask;
  logic          busy;
  logic          roll_done;
  logic          dice_valid;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  dice_roll_ctrl #(
    .NUM_DICE     (ND),
    .TUMBLE_TICKS (TT),
    .TICK_DIV     (TD),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .roll_trigger (roll_trigger),
    .hold_toggle  (hold_toggle),
    .hold_sel     (hold_sel),
    .clear_holds  (clear_holds),
    .dice_out     (dice_out),
    .hold_mask    (hold_mask),
    .busy         (busy),
    .roll_done    (roll_done),
    .dice_valid   (dice_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time-based view of a roll (accepted in cycle rt,
  // tumbling through rt+NCYC, done one cycle later), plus the LFSR stream.
  int          cyc;
  int          m_rt;
  int          m_done_at;
  bit          m_act;
  bit          m_pend;
  bit          m_valid;
  logic [15:0] m_lfsr;
  logic [2:0]  m_die [ND];
  logic [ND-1:0] m_mask;

  always @(posedge clk or negedge reset_n) begin : model
    logic [ND-1:0] ed;
    logic [ND-1:0] nmask;
    logic [2:0]    nd [ND];
    logic [2:0]    c;
    bit            bsy;
    bit            dn;
    bit            pend_n;
    if (!reset_n) begin
      m_lfsr    <= SEED;
      for (int i = 0; i < ND; i++) m_die[i] <= 3'd1;
      m_mask    <= '0;
      m_valid   <= 1'b0;
      m_pend    <= 1'b0;
      m_act     <= 1'b0;
      m_done_at <= -1;
      m_rt      <= 0;
      cyc       <= 0;
    end else begin
      bsy = m_act && (cyc > m_rt) && (cyc <= m_rt + NCYC);
      dn  = (cyc == m_done_at);
      ed  = m_mask;
      if (hold_toggle && (hold_sel < 3'(ND))) ed[hold_sel] = ~ed[hold_sel];
      if (clear_holds) ed = '0;
      nmask  = m_mask;
      pend_n = m_pend;
      for (int i = 0; i < ND; i++) nd[i] = m_die[i];
      if (bsy) begin
        if (clear_holds) pend_n = 1'b1;
        if (((cyc - m_rt) % TD) == 0) begin
          for (int i = 0; i < ND; i++) begin
            c = m_lfsr[3*i +: 3];
            if (!m_mask[i] && c >= 3'd1 && c <= 3'd6) nd[i] = c;
          end
        end
      end else if (dn) begin
        m_valid <= 1'b1;
        nmask   = m_pend ? '0 : ed;
        pend_n  = 1'b0;
        m_act   <= 1'b0;
      end else begin
        nmask = ed;
        if (roll_trigger) begin
          m_rt <= cyc;
          if (&ed) begin
            m_done_at <= cyc + 1;
          end else begin
            m_act     <= 1'b1;
            m_done_at <= cyc + NCYC + 1;
          end
        end
      end
      m_mask <= nmask;
      m_pend <= pend_n;
      for (int i = 0; i < ND; i++) m_die[i] <= nd[i];
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      cyc    <= cyc + 1;
    end
  end

  function automatic logic [3*ND-1:0] model_dice();
    logic [3*ND-1:0] v;
    for (int i = 0; i < ND; i++) v[3*i +: 3] = m_die[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      check("cyc_dice",  dice_out,   model_dice());
      check("cyc_mask",  hold_mask,  m_mask);
      check("cyc_busy",  busy,       m_act && (cyc > m_rt) && (cyc <= m_rt + NCYC));
      check("cyc_done",  roll_done,  cyc == m_done_at);
      check("cyc_valid", dice_valid, m_valid);
    end
  end

  task automatic step(input logic rt, input logic ht, input logic [2:0] hs, input logic ch);
    roll_trigger = rt;
    hold_toggle  = ht;
    hold_sel     = hs;
    clear_holds  = ch;
    @(negedge clk);
    roll_trigger = 1'b0;
    hold_toggle  = 1'b0;
    hold_sel     = 3'd0;
    clear_holds  = 1'b0;
  endtask

  function automatic bit faces_ok(input logic [3*ND-1:0] d);
    bit ok = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (d[3*i +: 3] < 3'd1 || d[3*i +: 3] > 3'd6) ok = 1'b0;
    end
    return ok;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    logic [3*ND-1:0] saved;
    reset_n      = 1'b0;
    roll_trigger = 1'b0;
    hold_toggle  = 1'b0;
    hold_sel     = 3'd0;
    clear_holds  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_dice",  dice_out,   15'h1249);
    check("rst_mask",  hold_mask,  5'b0);
    check("rst_busy",  busy,       1'b0);
    check("rst_done",  roll_done,  1'b0);
    check("rst_valid", dice_valid, 1'b0);
    reset_n = 1'b1;
    chk_on  = 1'b1;
    @(negedge clk);
    check("model_lfsr1", m_lfsr, 16'hE270);
    check("idle_dice", dice_out, 15'h1249);
    @(negedge clk);
    check("model_lfsr2", m_lfsr, 16'h7138);

    // Plain roll, no holds
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      check("s2_busy", busy, k <= 4);
      check("s2_done", roll_done, k == 5);
      if (k < 6) step(1'b0, 1'b0, 3'd0, 1'b0);
    end
    check("s2_valid", dice_valid, 1'b1);
    check("s2_faces", faces_ok(dice_out), 1'b1);

    // Holds on dice 0 and 3, out-of-range select ignored
    step(1'b0, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd3, 1'b0);
    check("s3_mask", hold_mask, 5'b01001);
    step(1'b0, 1'b1, 3'd6, 1'b0);
    check("s3_mask_sel6", hold_mask, 5'b01001);
    saved = dice_out;
    step(1'b1, 1'b0, 3'd0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s3_die0_held", dice_out[2:0],  saved[2:0]);
    check("s3_die3_held", dice_out[11:9], saved[11:9]);

    // All held: immediate DONE, dice untouched
    step(1'b0, 1'b1, 3'd1, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b0);
    step(1'b0, 1'b1, 3'd4, 1'b0);
    check("s4_mask", hold_mask, 5'b11111);
    saved = dice_out;
    step(1'b1, 1'b0, 3'd0, 1'b0);
    check("s4_done_t1", roll_done, 1'b1);
    check("s4_busy_t1", busy, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s4_done_t2", roll_done, 1'b0);
    check("s4_dice", dice_out, saved);
    step(1'b0, 1'b0, 3'd0, 1'b1);
    check("s4_cleared", hold_mask, 5'b0);

    // Edits during TUMBLE: deferred clear, ignored toggle and trigger
    step(1'b0, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 1'b1);
    check("s5_mask_t2", hold_mask, 5'b00010);
    check("s5_busy_t2", busy, 1'b1);
    repeat (2) step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s5_mask_t4", hold_mask, 5'b00010);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s5_done_t5", roll_done, 1'b1);
    check("s5_mask_t5", hold_mask, 5'b00010);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s5_mask_t6", hold_mask, 5'b0);
    check("s5_busy_t6", busy, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s5_busy_t7", busy, 1'b0);

    // Asynchronous reset mid-roll
    step(1'b0, 1'b1, 3'd2, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("s6_busy",  busy,       1'b0);
    check("s6_done",  roll_done,  1'b0);
    check("s6_mask",  hold_mask,  5'b0);
    check("s6_dice",  dice_out,   15'h1249);
    check("s6_valid", dice_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 3'd0, 1'b0);
    check("s6_busy_roll", busy, 1'b1);
    repeat (4) step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s6_done_roll", roll_done, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("s6_valid_roll", dice_valid, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
